// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default parameter values
//   pend_cnt_w()                    : width of the pending-register count
package regfile_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;

   // One extra bit so the count can reach 2**addr_w without wrapping.
   function automatic int pend_cnt_w(input int addr_w);
      return addr_w + 1;
   endfunction
endpackage

// File: rtl/regfile_popcnt.sv
// Combinational population count of the pending bitmap.
//   i_vec : bitmap, N bits
//   o_cnt : number of ones in i_vec, CW bits
module regfile_popcnt #(
   parameter int N  = 32,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  i_vec,
   output logic [CW-1:0] o_cnt
);
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < N; i++) begin
         o_cnt = o_cnt + CW'(i_vec[i]);
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// Two-write, two-read register file with a pending-producer scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rs, rt -> a, b      : combinational read ports
//   busy_a, busy_b      : pending flag for rs / rt
//   we0/wa0/wd0         : write port 0 (ALU writeback)
//   we1/wa1/wd1         : write port 1 (late load return, wins collisions)
//   set_pend, pend_addr : mark a destination register as pending
//   pend_cnt            : registered count of pending registers
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int R0_ZERO    = 1,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] rt,
   output logic [DATA_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] b,
   output logic                  busy_a,
   output logic                  busy_b,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] wa0,
   input  logic [DATA_WIDTH-1:0] wd0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] wa1,
   input  logic [DATA_WIDTH-1:0] wd1,
   input  logic                  set_pend,
   input  logic [ADDR_WIDTH-1:0] pend_addr,
   output logic [pend_cnt_w(ADDR_WIDTH)-1:0] pend_cnt
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = pend_cnt_w(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_pend;
   logic [DEPTH-1:0]      w_pend_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_wr0;
   logic                  w_wr1;
   logic [ADDR_WIDTH-1:0] w_raddr [2];
   logic [DATA_WIDTH-1:0] w_rdata [2];
   logic                  w_busy  [2];

   // A write to r0 is not a commit when r0 is hardwired.
   assign w_wr0 = we0 && !((R0_ZERO != 0) && (wa0 == '0));
   assign w_wr1 = we1 && !((R0_ZERO != 0) && (wa1 == '0));

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_wr0) r_mem[wa0] <= wd0;
         if (w_wr1) r_mem[wa1] <= wd1;
      end
   end

   // Set is applied after the clears so it wins on the same address.
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wr0)    w_pend_nxt[wa0]       = 1'b0;
      if (w_wr1)    w_pend_nxt[wa1]       = 1'b0;
      if (set_pend) w_pend_nxt[pend_addr] = 1'b1;
      if (R0_ZERO != 0) w_pend_nxt[0]     = 1'b0;
   end

   regfile_popcnt #(
      .N  (DEPTH),
      .CW (CW)
   ) u_popcnt (
      .i_vec (w_pend_nxt),
      .o_cnt (w_cnt_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign w_raddr[0] = rs;
   assign w_raddr[1] = rt;

   // Forwarding order: array, then port 0, then port 1; the r0 rule and
   // reset override everything so a held write cannot leak through.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rdata[p] = r_mem[w_raddr[p]];
         w_busy[p]  = r_pend[w_raddr[p]];
         if (BYPASS != 0) begin
            if (we0 && (wa0 == w_raddr[p])) w_rdata[p] = wd0;
            if (we1 && (wa1 == w_raddr[p])) w_rdata[p] = wd1;
            if (((w_wr0 && (wa0 == w_raddr[p])) || (w_wr1 && (wa1 == w_raddr[p])))
                && !(set_pend && (pend_addr == w_raddr[p])))
               w_busy[p] = 1'b0;
         end
         if ((R0_ZERO != 0) && (w_raddr[p] == '0)) w_rdata[p] = '0;
         if (!rst_n) begin
            w_rdata[p] = '0;
            w_busy[p]  = 1'b0;
         end
      end
   end

   assign a        = w_rdata[0];
   assign b        = w_rdata[1];
   assign busy_a   = w_busy[0];
   assign busy_b   = w_busy[1];
   assign pend_cnt = r_cnt;
endmodule
